// File: rtl/hyperbus_word_adapter.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_word_adapter
// Description : Word/register request front-end for hyperbus_interface.
//               Builds the CA packet, streams write bytes and assembles
//               read bytes, and returns one response per request.
// Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_word_adapter #(
    parameter int W_ADDR     = 22,
    parameter int W_BURSTLEN = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_write,
    input  logic                  req_reg,
    input  logic [W_ADDR-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [47:0]           cmd_addr,
    output logic                  start,
    input  logic                  start_rdy,
    output logic [W_BURSTLEN-1:0] burst_len,
    output logic [7:0]            wdata,
    input  logic                  wdata_rdy,
    input  logic [7:0]            rdata,
    input  logic                  rdata_vld
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DATA  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [W_BURSTLEN-1:0] c_bl_mem = W_BURSTLEN'(2);
    localparam logic [W_BURSTLEN-1:0] c_bl_reg = W_BURSTLEN'(1);
    localparam logic [2:0]            c_n_mem  = 3'd4;
    localparam logic [2:0]            c_n_reg  = 3'd2;

    state_t                r_state_q,     w_state_d;
    logic                  r_write_q,     w_write_d;
    logic                  r_reg_q,       w_reg_d;
    logic [47:0]           r_cmd_addr_q,  w_cmd_addr_d;
    logic [W_BURSTLEN-1:0] r_burst_len_q, w_burst_len_d;
    logic                  r_start_q,     w_start_d;
    logic [31:0]           r_shift_q,     w_shift_d;
    logic [2:0]            r_cnt_q,       w_cnt_d;
    logic                  r_busy_seen_q, w_busy_seen_d;
    logic                  r_rsp_vld_q,   w_rsp_vld_d;
    logic                  r_rsp_write_q, w_rsp_write_d;
    logic [31:0]           r_rsp_rdata_q, w_rsp_rdata_d;

    logic [31:0] w_hw;
    logic [47:0] w_cmd;
    logic [2:0]  w_n;
    logic        w_cnt_done;

    // Memory requests carry a word address; HyperBus addresses halfwords.
    assign w_hw       = req_reg ? 32'(req_addr) : 32'({req_addr, 1'b0});
    assign w_cmd      = {~req_write, req_reg, 1'b1, w_hw[31:3], 13'h0, w_hw[2:0]};
    assign w_n        = r_reg_q ? c_n_reg : c_n_mem;
    assign w_cnt_done = (r_cnt_q == w_n);

    always_comb begin
        w_state_d     = r_state_q;
        w_write_d     = r_write_q;
        w_reg_d       = r_reg_q;
        w_cmd_addr_d  = r_cmd_addr_q;
        w_burst_len_d = r_burst_len_q;
        w_start_d     = r_start_q;
        w_shift_d     = r_shift_q;
        w_cnt_d       = r_cnt_q;
        w_busy_seen_d = r_busy_seen_q;
        w_rsp_vld_d   = r_rsp_vld_q;
        w_rsp_write_d = r_rsp_write_q;
        w_rsp_rdata_d = r_rsp_rdata_q;

        case (r_state_q)
            S_IDLE: begin
                if (req_vld) begin
                    w_write_d     = req_write;
                    w_reg_d       = req_reg;
                    w_cmd_addr_d  = w_cmd;
                    w_burst_len_d = req_reg ? c_bl_reg : c_bl_mem;
                    // Register writes only carry 16 bits; left-align them.
                    w_shift_d     = req_reg ? {req_wdata[15:0], 16'h0} : req_wdata;
                    w_start_d     = 1'b1;
                    w_state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (r_start_q && start_rdy) begin
                    w_start_d     = 1'b0;
                    w_cnt_d       = 3'd0;
                    w_busy_seen_d = 1'b0;
                    w_state_d     = S_DATA;
                end
            end

            S_DATA: begin
                w_busy_seen_d = r_busy_seen_q | ~start_rdy;
                if (r_write_q) begin
                    if (wdata_rdy && !w_cnt_done) begin
                        w_shift_d = {r_shift_q[23:0], 8'h0};
                        w_cnt_d   = r_cnt_q + 3'd1;
                    end
                end else begin
                    if (rdata_vld && !w_cnt_done) begin
                        w_shift_d = {r_shift_q[23:0], rdata};
                        w_cnt_d   = r_cnt_q + 3'd1;
                    end
                end
                // The interface must have gone busy and returned to idle.
                if (w_cnt_done && r_busy_seen_q && start_rdy) begin
                    w_rsp_vld_d   = 1'b1;
                    w_rsp_write_d = r_write_q;
                    if (r_write_q) begin
                        w_rsp_rdata_d = 32'h0;
                    end else if (r_reg_q) begin
                        w_rsp_rdata_d = {16'h0, r_shift_q[15:0]};
                    end else begin
                        w_rsp_rdata_d = r_shift_q;
                    end
                    w_state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (rsp_rdy) begin
                    w_rsp_vld_d = 1'b0;
                    w_state_d   = S_IDLE;
                end
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_write_q     <= 1'b0;
            r_reg_q       <= 1'b0;
            r_cmd_addr_q  <= 48'h0;
            r_burst_len_q <= c_bl_mem;
            r_start_q     <= 1'b0;
            r_shift_q     <= 32'h0;
            r_cnt_q       <= 3'd0;
            r_busy_seen_q <= 1'b0;
            r_rsp_vld_q   <= 1'b0;
            r_rsp_write_q <= 1'b0;
            r_rsp_rdata_q <= 32'h0;
        end else begin
            r_state_q     <= w_state_d;
            r_write_q     <= w_write_d;
            r_reg_q       <= w_reg_d;
            r_cmd_addr_q  <= w_cmd_addr_d;
            r_burst_len_q <= w_burst_len_d;
            r_start_q     <= w_start_d;
            r_shift_q     <= w_shift_d;
            r_cnt_q       <= w_cnt_d;
            r_busy_seen_q <= w_busy_seen_d;
            r_rsp_vld_q   <= w_rsp_vld_d;
            r_rsp_write_q <= w_rsp_write_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
        end
    end

    assign req_rdy   = (r_state_q == S_IDLE);
    assign start     = r_start_q;
    assign cmd_addr  = r_cmd_addr_q;
    assign burst_len = r_burst_len_q;
    assign rsp_vld   = r_rsp_vld_q;
    assign rsp_write = r_rsp_write_q;
    assign rsp_rdata = r_rsp_rdata_q;
    assign wdata     = (r_state_q == S_DATA && r_write_q && !w_cnt_done) ? r_shift_q[31:24] : 8'h0;

endmodule
`default_nettype wire

// File: doc/hyperbus_word_adapter.md
# hyperbus_word_adapter

Upstream command/data stage for `hyperbus_interface`. Accepts single 32-bit word memory accesses and 16-bit register accesses on a valid/ready request port, then builds the 48-bit HyperBus CA packet and issues `start`. It serialises write data big-endian onto the byte-wide `wdata`/`wdata_rdy` stream and reassembles `rdata`/`rdata_vld` bytes into a word. It returns one response per request on a valid/ready response port.

## Interface
- `W_ADDR`, 22, request word-address width (23-bit HyperBus halfword address space)
- `W_BURSTLEN`, 5, width of `burst_len`; must match `hyperbus_interface`
- `clk` in 1 — sole clock
- `rst` in 1 — reset, asynchronous, active-high
- `req_vld` in 1 — request valid
- `req_rdy` out 1 — request accepted when `req_vld && req_rdy`
- `req_write` in 1 — 1 = write, 0 = read
- `req_reg` in 1 — 1 = register space, 0 = memory space
- `req_addr` in W_ADDR — memory: word address; register: halfword register address (CR0 = 0x800)
- `req_wdata` in 32 — write data; register writes use [15:0]
- `rsp_vld` out 1 — response valid, held until `rsp_rdy`
- `rsp_rdy` in 1 — response accept
- `rsp_write` out 1 — echoes `req_write` of the completed request
- `rsp_rdata` out 32 — read data; register reads are zero-extended 16-bit; 0 for writes
- `cmd_addr` out 48 — CA packet to `hyperbus_interface`
- `start` out 1 — sequence start
- `start_rdy` in 1 — interface idle/ready
- `burst_len` out W_BURSTLEN — halfwords per sequence
- `wdata` out 8, `wdata_rdy` in 1 — write byte stream
- `rdata` in 8, `rdata_vld` in 1 — read byte stream

## Operation
- States: IDLE, ISSUE, DATA, RESP.
- `req_rdy = (state == IDLE)`.
- IDLE: on request handshake, capture write, reg, address and wdata, then go to ISSUE.
- Halfword address `hw`, 32-bit zero-extended: memory → `{req_addr, 1'b0}`; register → `req_addr`.
- `cmd_addr = {~write, reg, 1'b1, hw[31:3], 13'h0, hw[2:0]}`. Bit 45 (linear burst) is always 1.
- `burst_len` = 2 for memory, 1 for register. Byte target N = 4 or 2 respectively.
- ISSUE: `start` = 1 until `start && start_rdy`, then go to DATA. Clear byte count and the `busy_seen` flag.
- DATA, write:
  - `wdata` = top byte of the write shift register.
  - Memory load: `req_wdata[31:0]`. Register load: `{req_wdata[15:0], 16'h0}`.
  - On each `wdata_rdy`: shift left 8 and increment count.
  - `wdata_rdy` after count == N: `wdata` = 0, no count.
- DATA, read:
  - On each `rdata_vld` while count < N: `rshift <= {rshift[23:0], rdata}` and increment count.
  - Bytes beyond N are discarded.
- `busy_seen` is set on any DATA cycle with `start_rdy` = 0.
- DATA exits to RESP when count == N and `busy_seen` and `start_rdy` are all true.
- RESP:
  - `rsp_vld` = 1.
  - `rsp_rdata` = `rshift` for memory reads, `{16'h0, rshift[15:0]}` for register reads, 0 for writes.
  - On `rsp_rdy`, go to IDLE.
- One request outstanding at a time; no pipelining.

## Timing
- Reset (async, immediate):
  - State → IDLE.
  - `start`, `rsp_vld`, `rsp_write`, `rsp_rdata`, `cmd_addr`, `wdata` = 0.
  - `burst_len` = 2.
  - `req_rdy` = 1.
- Reset mid-sequence abandons the transfer with no response. The downstream interface is reset from the same source.
- Request accepted at edge T → `start` high in cycle T+1 with `cmd_addr`/`burst_len` already stable. Both hold stable until the DATA→IDLE return.
- `start` high ≥ 1 cycle; dropped the cycle after the `start && start_rdy` edge.
- `wdata` is valid combinationally from the shift register in the same cycle as `wdata_rdy`.
- `rsp_vld` asserts one cycle after the completion condition. `req_rdy` reasserts the cycle after the `rsp_rdy` handshake.
- Minimum request-to-request spacing: 1 cycle in IDLE.
- `req_vld` during non-IDLE states is ignored (`req_rdy` = 0).
- `start_rdy` still high in the first DATA cycle does not complete the sequence: `busy_seen` must be set first.

## Test plan
- Memory write, word addr 0x10, data 0x01234567:
  - `cmd_addr` = 0x2000_0004_0000, `burst_len` = 2.
  - Bytes 01,23,45,67 on successive `wdata_rdy`.
  - One `rsp_vld` with `rsp_write` = 1 and `rsp_rdata` = 0.
- Memory read of the same address against the s27kl0641 model → `rsp_rdata` = 0x01234567, `cmd_addr` = 0xA000_0004_0000.
- Register read, addr 0x800 → `cmd_addr` = 0xE000_0100_0000, `burst_len` = 1, `rsp_rdata` = 0x00008FEF at latency 3.
- Register write of 0x8FEF to 0x800 (`cmd_addr` = 0x6000_0100_0000, bytes 8F,EF), then read back → 0x00008FEF.
- Backpressure: hold `rsp_rdy` = 0 for 10 cycles → `rsp_vld` and `rsp_rdata` stable, `req_rdy` = 0 throughout.
- Reset asserted mid-read after 2 bytes → `start` = 0, state IDLE, no `rsp_vld`. A subsequent 1000-word random write/readback sweep then passes with zero mismatches.
